// File: rtl/ks_pipe_sub.sv
// Pipelined Kogge-Stone subtractor: Diff = A - B - Bin, Bout = borrow-out, one prefix level per stage.
// Optional flag outputs Zero/Ovf are built when KS_SUB_FLAGS_EN is defined.
module ks_pipe_sub #(
    parameter  int N     = 4,
    localparam int LOG2N = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Diff,
    output logic         Bout
`ifdef KS_SUB_FLAGS_EN
    ,
    output logic         Zero,
    output logic         Ovf
`endif
);

    localparam int LAST = LOG2N;

    logic               adv;
    logic [LOG2N+1:0]   vld;

    logic [N-1:0]       p_q  [LOG2N+1];
    logic [N-1:0]       g_q  [LOG2N+1];
    logic [N-1:0]       p0_q [LOG2N+1];
    logic [LOG2N:0]     cin_q;

    logic [N-1:0]       p_d  [LOG2N+1];
    logic [N-1:0]       g_d  [LOG2N+1];
    logic [N-1:0]       p0_d [LOG2N+1];
    logic [LOG2N:0]     cin_d;

    logic [N:0]         c;
    logic [N-1:0]       diff_d;
    logic               bout_d;

    assign adv       = !out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[LOG2N+1];

    // Subtraction as A + ~B + ~Bin, so the adder's P/G formulation carries over.
    always_comb begin
        p_d[0]   = A ^ ~B;
        g_d[0]   = A & ~B;
        p0_d[0]  = A ^ ~B;
        cin_d    = '0;
        cin_d[0] = ~Bin;
        for (int k = 1; k <= LOG2N; k++) begin
            p_d[k]   = p_q[k-1];
            g_d[k]   = g_q[k-1];
            p0_d[k]  = p0_q[k-1];
            cin_d[k] = cin_q[k-1];
            for (int i = (1 << (k-1)); i < N; i++) begin
                g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i - (1 << (k-1))]);
                p_d[k][i] = p_q[k-1][i] & p_q[k-1][i - (1 << (k-1))];
            end
        end
    end

    // After the last level each (P,G) spans bit 0, so carries only need cin folded in.
    always_comb begin
        c    = '0;
        c[0] = cin_q[LAST];
        for (int i = 0; i < N; i++) begin
            c[i+1] = g_q[LAST][i] | (p_q[LAST][i] & cin_q[LAST]);
        end
        diff_d = p0_q[LAST] ^ c[N-1:0];
        bout_d = ~c[N];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld   <= '0;
            cin_q <= '0;
            for (int s = 0; s <= LOG2N; s++) begin
                p_q[s]  <= '0;
                g_q[s]  <= '0;
                p0_q[s] <= '0;
            end
        end else if (adv) begin
            vld   <= {vld[LOG2N:0], in_valid};
            cin_q <= cin_d;
            for (int s = 0; s <= LOG2N; s++) begin
                p_q[s]  <= p_d[s];
                g_q[s]  <= g_d[s];
                p0_q[s] <= p0_d[s];
            end
        end
    end

    // Result registers only load real data, so they stay at their reset value until the first result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Diff <= '0;
            Bout <= 1'b0;
        end else if (adv && vld[LAST]) begin
            Diff <= diff_d;
            Bout <= bout_d;
        end
    end

`ifdef KS_SUB_FLAGS_EN
    logic [LOG2N:0] msb_a_q;
    logic [LOG2N:0] msb_b_q;
    logic [LOG2N:0] msb_a_d;
    logic [LOG2N:0] msb_b_d;
    logic           ovf_d;

    always_comb begin
        msb_a_d = msb_a_q << 1;
        msb_b_d = msb_b_q << 1;
        msb_a_d[0] = A[N-1];
        msb_b_d[0] = B[N-1];
        ovf_d = (msb_a_q[LAST] != msb_b_q[LAST]) & (diff_d[N-1] != msb_a_q[LAST]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msb_a_q <= '0;
            msb_b_q <= '0;
        end else if (adv) begin
            msb_a_q <= msb_a_d;
            msb_b_q <= msb_b_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Zero <= 1'b0;
            Ovf  <= 1'b0;
        end else if (adv && vld[LAST]) begin
            Zero <= (diff_d == '0);
            Ovf  <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_ks_pipe_sub.sv
// Bench for ks_pipe_sub (N=4): arithmetic scoreboard plus directed literal cases,
// backpressure, mid-flight reset and an exhaustive sweep under random stalls.
module tb_ks_pipe_sub;

    localparam int N   = 4;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic         Bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] Diff;
    logic         Bout;
`ifdef KS_SUB_FLAGS_EN
    logic         Zero;
    logic         Ovf;
`endif

    ks_pipe_sub #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Bin(Bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .Diff(Diff), .Bout(Bout)
`ifdef KS_SUB_FLAGS_EN
        , .Zero(Zero), .Ovf(Ovf)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int or_mode = 1;
    int n_in = 0;
    int n_out = 0;
    int n_flushed = 0;

    typedef struct packed {
        logic [N-1:0] diff;
        logic         bout;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
        exp_t e;
        int   d;
        d      = int'(a) - int'(b) - int'(bin);
        e.bout = (d < 0);
        e.diff = N'(d);
        e.zero = (e.diff == '0);
        e.ovf  = (a[N-1] != b[N-1]) && (e.diff[N-1] != a[N-1]);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard: the older result leaves before the new operand is queued.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_flushed += exp_q.size();
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("sb_spurious_out", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_result", {Bout, Diff}, {e.bout, e.diff});
`ifdef KS_SUB_FLAGS_EN
                    check("sb_flags", {Zero, Ovf}, {e.zero, e.ovf});
`endif
                end
            end
            if (in_valid && in_ready) begin
                n_in++;
                exp_q.push_back(model(A, B, Bin));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that took the operand.
    task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin, output int acc_cyc);
        int waited;
        waited   = 0;
        A        = a;
        B        = b;
        Bin      = bin;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        acc_cyc = cyc;
        if (!in_ready) check("push_timeout", 0, 1);
        step();
        in_valid = 1'b0;
    endtask

    // Returns on the falling edge where the result is visible.
    task automatic do_one(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                          input logic [N-1:0] ed, input logic eb, input string name);
        int ac;
        bit got;
        push(a, b, bin, ac);
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clk);
            got = out_valid;
        end
        check({name, "_seen"}, 32'(got), 1);
        check({name, "_latency"}, cyc - ac, LAT);
        check({name, "_diff"}, Diff, ed);
        check({name, "_bout"}, Bout, eb);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int w = 0; w < 400 && !done; w++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !out_valid;
        end
        check("drain_empty", 32'(done), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int idx;
        int base;
        int ac;
        bit flag;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", Diff, 0);
        check("rst_bout", Bout, 0);
        check("rst_in_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);
        step();

        do_one(4'd9, 4'd3, 1'b0, 4'h6, 1'b0, "d_9_3");        step();
        do_one(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, "d_3_9");        step();
        do_one(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, "d_0_0_b");      step();
        do_one(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, "d_f_f_b");      step();
`ifdef KS_SUB_FLAGS_EN
        do_one(4'h8, 4'h8, 1'b0, 4'h0, 1'b0, "f_8_8");
        check("f_8_8_zero", Zero, 1);
        check("f_8_8_ovf", Ovf, 0);
        step();
        do_one(4'h8, 4'h1, 1'b0, 4'h7, 1'b0, "f_8_1");
        check("f_8_1_zero", Zero, 0);
        check("f_8_1_ovf", Ovf, 1);
        step();
`endif

        // Backpressure: pipe holds exactly LAT transactions, then releases them back to back.
        drain();
        or_mode = 0;
        step();
        acc = 0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            A = N'(idx * 3 + 5);
            B = N'(idx * 7);
            Bin = 1'(idx);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                acc++;
                idx++;
            end
            step();
        end
        check("cap_accepted", acc, LAT);
        @(negedge clk);
        check("cap_in_ready_low", in_ready, 0);
        check("cap_out_valid_high", out_valid, 1);
        or_mode = 1;
        step();
        @(negedge clk);
        check("resume_in_ready", in_ready, 1);
        check("resume_out_valid", out_valid, 1);
        if (in_ready) idx++;
        flag = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            A = N'(idx * 3 + 5);
            B = N'(idx * 7);
            Bin = 1'(idx);
            @(negedge clk);
            if (!out_valid) flag = 1'b0;
            if (in_ready) idx++;
        end
        check("drain_consecutive", 32'(flag), 1);
        step();
        in_valid = 1'b0;
        drain();
        step();

        // Reset with three transactions in flight, the oldest already presented.
        push(4'd7, 4'd2, 1'b0, ac);
        push(4'd1, 4'd4, 1'b1, ac);
        push(4'd12, 4'd5, 1'b0, ac);
        step();
        check("midrst_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_diff", Diff, 0);
        check("midrst_bout", Bout, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        flag = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) flag = 1'b0;
        end
        check("midrst_no_ghost", 32'(flag), 1);
        check("midrst_flushed", n_flushed, 3);
        step();
        do_one(4'd5, 4'd2, 1'b1, 4'h2, 1'b0, "post_midrst");
        step();

        // Exhaustive sweep with random output stalls.
        or_mode = 2;
        base = n_in;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    push(N'(a), N'(b), 1'(bi), ac);
                end
            end
        end
        check("sweep_accepted", n_in - base, 512);
        or_mode = 1;
        drain();
        check("out_count", n_out, n_in - n_flushed);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
